// File: rtl/montgomery_mul_r2.sv
// Bit-serial radix-2 Montgomery multiplier.
// Computes io_A * io_B * 2^-WIDTH mod io_M, one multiplier bit per cycle.
//
// Ports:
//   clock          rising-edge system clock
//   reset          asynchronous, active-high; clears all state
//   io_in_valid    operand tuple {io_A, io_B, io_M} is valid
//   io_in_ready    tuple can be accepted (IDLE only)
//   io_A, io_B     operands, both expected < io_M
//   io_M           modulus, expected odd
//   io_out_valid   io_result / io_err are valid (held until io_out_ready)
//   io_out_ready   downstream accepts the result
//   io_result      A*B*2^-WIDTH mod M (0 when io_M was even)
//   io_err         modulus was even
//   io_busy        iterating or doing the final reduction
//
// Latency is fixed: io_out_valid rises WIDTH+2 edges after the accepting edge.

module montgomery_mul_r2 #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_A,
  input  logic [WIDTH-1:0] io_B,
  input  logic [WIDTH-1:0] io_M,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_result,
  output logic             io_err,
  output logic             io_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // shifted right each iteration; a_q[0] is A[i]
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH+1:0] s_q, s_d;        // accumulator, stays < 2M
  logic [CW-1:0]    i_q, i_d;
  logic             err_q, err_d;
  logic             fin_q, fin_d;    // second cycle of FINAL
  logic             ge_q, ge_d;      // S >= M
  logic [WIDTH-1:0] diff_q, diff_d;  // S - M, low WIDTH bits
  logic [WIDTH-1:0] result_q, result_d;

  // Pre-shift sum is < 4M; one extra bit keeps even out-of-contract
  // operands from wrapping before the shift.
  logic             q_bit;
  logic [WIDTH+2:0] sum;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    s_d      = s_q;
    i_d      = i_q;
    err_d    = err_q;
    fin_d    = fin_q;
    ge_d     = ge_q;
    diff_d   = diff_q;
    result_d = result_q;

    q_bit = s_q[0] ^ (a_q[0] & b_q[0]);
    sum   = {1'b0, s_q}
          + (a_q[0] ? {3'b000, b_q} : '0)
          + (q_bit  ? {3'b000, m_q} : '0);

    unique case (state_q)
      IDLE: begin
        if (io_in_valid) begin
          a_d     = io_A;
          b_d     = io_B;
          m_d     = io_M;
          s_d     = '0;
          i_d     = '0;
          err_d   = ~io_M[0];
          fin_d   = 1'b0;
          state_d = CALC;
        end
      end

      CALC: begin
        s_d = (WIDTH + 2)'(sum >> 1);
        a_d = a_q >> 1;
        i_d = i_q + CW'(1);
        if (i_q == LAST) begin
          state_d = FINAL;
        end
      end

      // FINAL spans two cycles: the wide compare/subtract is registered
      // first, then the select; this sets the WIDTH+2 latency.
      FINAL: begin
        if (!fin_q) begin
          ge_d   = (s_q >= {2'b00, m_q});
          diff_d = WIDTH'(s_q - {2'b00, m_q});
          fin_d  = 1'b1;
        end else begin
          result_d = err_q ? '0 : (ge_q ? diff_q : WIDTH'(s_q));
          fin_d    = 1'b0;
          state_d  = DONE;
        end
      end

      DONE: begin
        if (io_out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      s_q      <= '0;
      i_q      <= '0;
      err_q    <= 1'b0;
      fin_q    <= 1'b0;
      ge_q     <= 1'b0;
      diff_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      s_q      <= s_d;
      i_q      <= i_d;
      err_q    <= err_d;
      fin_q    <= fin_d;
      ge_q     <= ge_d;
      diff_q   <= diff_d;
      result_q <= result_d;
    end
  end

  assign io_in_ready  = (state_q == IDLE);
  assign io_out_valid = (state_q == DONE);
  assign io_busy      = (state_q == CALC) || (state_q == FINAL);
  assign io_result    = result_q;
  assign io_err       = err_q;

endmodule

// File: tb/tb_montgomery_mul_r2.sv
// Self-checking bench for montgomery_mul_r2 at WIDTH=8 and WIDTH=128.
// Expected results come from table constants or from a modular-arithmetic
// reference: (A*B mod M) multiplied by 2^-W via repeated modular halving.

module tb_montgomery_mul_r2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst8, v8, rdy8, ov8, or8, e8, busy8;
  logic [7:0] a8, b8, m8, r8;
  // WIDTH=128 instance
  logic         rst128, v128, rdy128, ov128, or128, e128, busy128;
  logic [127:0] a128, b128, m128, r128;

  montgomery_mul_r2 #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst8), .io_in_valid(v8), .io_in_ready(rdy8),
    .io_A(a8), .io_B(b8), .io_M(m8), .io_out_valid(ov8), .io_out_ready(or8),
    .io_result(r8), .io_err(e8), .io_busy(busy8)
  );

  montgomery_mul_r2 #(.WIDTH(128)) dut128 (
    .clock(clk), .reset(rst128), .io_in_valid(v128), .io_in_ready(rdy128),
    .io_A(a128), .io_B(b128), .io_M(m128), .io_out_valid(ov128), .io_out_ready(or128),
    .io_result(r128), .io_err(e128), .io_busy(busy128)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Montgomery product by definition: r * 2^w == a*b (mod m).
  function automatic logic [127:0] ref_mont(input logic [127:0] a, input logic [127:0] b,
                                            input logic [127:0] m, input int unsigned w);
    logic [255:0] p;
    logic [128:0] x;
    if (m[0] == 1'b0) return '0;
    p = ({128'b0, a} * {128'b0, b}) % {128'b0, m};
    x = p[128:0];
    for (int unsigned k = 0; k < w; k++)
      x = x[0] ? ((x + {1'b0, m}) >> 1) : (x >> 1);
    return x[127:0];
  endfunction

  task automatic xact8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       input logic [7:0] er, input logic ee, input string tag);
    int unsigned n, lat, leak;
    bit seen;
    @(posedge clk); #1;
    n = 0;
    while (!rdy8 && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, " in_ready idle"}, rdy8, 1);
    a8 = a; b8 = b; m8 = m; v8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); m8 = 8'($urandom);
    lat = 0; leak = 0; seen = 0;
    while (!seen && lat < 60) begin
      @(posedge clk); #1; lat++;
      if (ov8) seen = 1;
      else if (rdy8 || !busy8) leak++;
    end
    chk({tag, " latency"}, lat, 10);
    chk({tag, " result"}, r8, er);
    chk({tag, " err"}, e8, ee);
    chk({tag, " ready/busy while working"}, {leak[15:0], rdy8, busy8}, 0);
  endtask

  task automatic xact128(input logic [127:0] a, input logic [127:0] b, input logic [127:0] m,
                         input logic [127:0] er, input int unsigned hold, input string tag);
    int unsigned n, lat, bad;
    bit seen;
    logic [127:0] held;
    @(posedge clk); #1;
    n = 0;
    while (!rdy128 && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, " in_ready idle"}, rdy128, 1);
    a128 = a; b128 = b; m128 = m; v128 = 1'b1; or128 = (hold == 0);
    @(posedge clk); #1;
    v128 = 1'b0;
    a128 = {$urandom, $urandom, $urandom, $urandom};
    b128 = {$urandom, $urandom, $urandom, $urandom};
    lat = 0; seen = 0;
    while (!seen && lat < 300) begin
      @(posedge clk); #1; lat++;
      if (ov128) seen = 1;
    end
    chk({tag, " latency"}, lat, 130);
    chk({tag, " result"}, r128, er);
    chk({tag, " err"}, e128, {127'b0, ~m[0]});
    if (hold > 0) begin
      held = r128; bad = 0;
      for (int unsigned h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (ov128 !== 1'b1 || r128 !== held || rdy128 !== 1'b0) bad++;
      end
      chk({tag, " backpressure hold"}, bad, 0);
      or128 = 1'b1;
      @(posedge clk); #1;
      chk({tag, " after handshake valid/ready"}, {ov128, rdy128}, 2'b01);
    end
  endtask

  typedef struct {
    logic [7:0] a, b, m, r;
    logic       e;
  } vec8_t;

  vec8_t tbl[7];

  initial begin
    logic [127:0] ma, aa, bb, mm;
    logic [7:0]   ra, rb, rm;

    tbl[0] = '{a: 8'd5,  b: 8'd7, m: 8'd13, r: 8'd1, e: 1'b0};
    tbl[1] = '{a: 8'd1,  b: 8'd1, m: 8'd13, r: 8'd3, e: 1'b0};
    tbl[2] = '{a: 8'd12, b: 8'd12, m: 8'd13, r: 8'd3, e: 1'b0};
    tbl[3] = '{a: 8'd0,  b: 8'd9, m: 8'd13, r: 8'd0, e: 1'b0};
    tbl[4] = '{a: 8'd5,  b: 8'd7, m: 8'd12, r: 8'd0, e: 1'b1};
    tbl[5] = '{a: 8'd5,  b: 8'd7, m: 8'd13, r: 8'd1, e: 1'b0};
    tbl[6] = '{a: 8'd6,  b: 8'd4, m: 8'd11, r: 8'd8, e: 1'b0};

    rst8 = 1'b1; rst128 = 1'b1;
    v8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; m8 = '0;
    v128 = 1'b0; or128 = 1'b1; a128 = '0; b128 = '0; m128 = '0;
    #12;
    chk("reset8 outputs", {rdy8, ov8, r8, e8, busy8}, {1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
    chk("reset128 outputs", {rdy128, ov128, e128, busy128}, 4'b1000);
    chk("reset128 result", r128, 0);
    @(negedge clk); rst8 = 1'b0; rst128 = 1'b0;

    for (int unsigned i = 0; i < 7; i++)
      xact8(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].r, tbl[i].e, $sformatf("tbl[%0d]", i));

    for (int unsigned i = 0; i < 1000; i++) begin
      rm = 8'($urandom_range(3, 255)) | 8'd1;
      ra = 8'($urandom % rm);
      rb = 8'($urandom % rm);
      xact8(ra, rb, rm, 8'(ref_mont({120'b0, ra}, {120'b0, rb}, {120'b0, rm}, 8)), 1'b0,
            $sformatf("rand8[%0d]", i));
    end

    mm = '1;
    mm = mm - 128'd158;
    xact128(128'd159, 128'h1234, mm, 128'h1234, 20, "r-mod-m backpressure");
    xact128(128'd159, 128'h1234, mm, 128'h1234, 0, "r-mod-m");
    ma = mm - 128'd1;
    xact128(ma, ma, mm, ref_mont(ma, ma, mm, 128), 0, "max operands");
    ma = mm - 128'd1;
    xact128(ma, 128'd7, mm - 128'd1, 128'd0, 0, "even modulus");

    for (int unsigned i = 0; i < 200; i++) begin
      mm = {$urandom, $urandom, $urandom, $urandom};
      mm[127] = 1'b1; mm[0] = 1'b1;
      aa = {$urandom, $urandom, $urandom, $urandom} % mm;
      bb = {$urandom, $urandom, $urandom, $urandom} % mm;
      xact128(aa, bb, mm, ref_mont(aa, bb, mm, 128), 0, $sformatf("rand128[%0d]", i));
    end

    // Asynchronous reset in the middle of CALC.
    mm = '1;
    mm = mm - 128'd158;
    @(posedge clk); #1;
    a128 = 128'd12345; b128 = 128'd678; m128 = mm; v128 = 1'b1;
    @(posedge clk); #1;
    v128 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("mid-calc busy", busy128, 1);
    #2 rst128 = 1'b1;
    #1;
    chk("async reset outputs", {rdy128, ov128, e128, busy128}, 4'b1000);
    chk("async reset result", r128, 0);
    @(negedge clk); rst128 = 1'b0;
    xact128(128'd159, 128'hbeef, mm, 128'hbeef, 0, "after reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
